// File: rtl/viterbi_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : viterbi_decoder_if                                        |
// | Brief    : Coded-stream input and decoded-bit output bundle.         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface viterbi_decoder_if;
  logic [1:0] AB;
  logic [1:0] valid_in;
  logic       flush;
  logic       bit_out;
  logic       valid_out;
  logic       busy;
  logic       done;

  modport master (
    output AB, valid_in, flush,
    input  bit_out, valid_out, busy, done
  );

  modport slave (
    input  AB, valid_in, flush,
    output bit_out, valid_out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/viterbi_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : viterbi_decoder                                           |
// | Brief    : K=7 r=1/2 (133,171) hard-decision register-exchange       |
// |            Viterbi decoder with erasure support and end flush.       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module viterbi_decoder #(
  parameter int TB_DEPTH = 42,
  parameter int PM_W     = 8
) (
  input  logic               Clk,
  input  logic               reset,
  viterbi_decoder_if.slave   bus
);

  localparam int         c_NSTATES = 64;
  localparam logic [6:0] c_D       = 7'(TB_DEPTH);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t              r_state, w_state_next;
  logic [PM_W-1:0]     r_pm        [c_NSTATES];
  logic [PM_W-1:0]     w_pm_next   [c_NSTATES];
  logic [TB_DEPTH-1:0] r_surv      [c_NSTATES];
  logic [TB_DEPTH-1:0] w_surv_next [c_NSTATES];
  logic [6:0]          r_n, w_n_next, r_cnt;
  logic [5:0]          w_best;
  logic [PM_W-1:0]     w_best_pm;
  logic [TB_DEPTH-1:0] w_flush_vec;
  logic                w_step, w_flush_req, w_empty_flush;
  logic                r_bit, r_valid, r_done;

  // Erased bits (mask bit low) contribute nothing to the distance.
  function automatic logic [1:0] f_bm(input logic [6:0] d, input logic [1:0] ab,
                                      input logic [1:0] vin);
    logic ea, eb;
    ea = (^(d & 7'b1011011)) ^ ab[1];
    eb = (^(d & 7'b1111001)) ^ ab[0];
    return {1'b0, ea & vin[1]} + {1'b0, eb & vin[0]};
  endfunction

  always_comb begin
    logic [5:0]      w_ms, w_p0, w_p1;
    logic [PM_W-1:0] w_c0, w_c1, w_diff;
    w_ms = '0; w_p0 = '0; w_p1 = '0; w_c0 = '0; w_c1 = '0; w_diff = '0;
    for (int m = 0; m < c_NSTATES; m++) begin
      w_ms   = 6'(m);
      w_p0   = {w_ms[4:0], 1'b0};
      w_p1   = {w_ms[4:0], 1'b1};
      w_c0   = r_pm[w_p0] + {{(PM_W-2){1'b0}}, f_bm({w_ms[5], w_p0}, bus.AB, bus.valid_in)};
      w_c1   = r_pm[w_p1] + {{(PM_W-2){1'b0}}, f_bm({w_ms[5], w_p1}, bus.AB, bus.valid_in)};
      w_diff = w_c1 - w_c0;
      if (w_diff[PM_W-1]) begin
        w_pm_next[m]   = w_c1;
        w_surv_next[m] = {r_surv[w_p1][TB_DEPTH-2:0], w_ms[5]};
      end else begin
        w_pm_next[m]   = w_c0;
        w_surv_next[m] = {r_surv[w_p0][TB_DEPTH-2:0], w_ms[5]};
      end
    end
  end

  // Modulo argmin; strict compare keeps the lowest index on ties.
  always_comb begin
    logic [PM_W-1:0] w_d;
    w_best    = '0;
    w_best_pm = r_pm[0];
    w_d       = '0;
    for (int s = 1; s < c_NSTATES; s++) begin
      w_d = r_pm[s] - w_best_pm;
      if (w_d[PM_W-1]) begin
        w_best    = 6'(s);
        w_best_pm = r_pm[s];
      end
    end
  end

  assign w_flush_vec = r_surv[w_best] >> (r_cnt - 7'd1);

  always_comb begin
    w_step        = (r_state == ST_RUN) && (bus.valid_in != 2'b00);
    w_n_next      = (w_step && (r_n < c_D)) ? r_n + 7'd1 : r_n;
    w_flush_req   = (r_state == ST_RUN) && bus.flush;
    w_empty_flush = w_flush_req && (w_n_next == 7'd0);
    w_state_next  = r_state;
    case (r_state)
      ST_RUN:   if (w_flush_req && (w_n_next != 7'd0)) w_state_next = ST_FLUSH;
      ST_FLUSH: if (r_cnt == 7'd1) w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_n     <= '0;
      r_cnt   <= '0;
      r_bit   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      for (int s = 0; s < c_NSTATES; s++) begin
        r_pm[s]   <= (s == 0) ? '0 : PM_W'(64);
        r_surv[s] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (r_state == ST_RUN) begin
        if (w_step) begin
          for (int s = 0; s < c_NSTATES; s++) begin
            r_pm[s]   <= w_pm_next[s];
            r_surv[s] <= w_surv_next[s];
          end
          r_n <= w_n_next;
          if (r_n >= c_D) begin
            r_bit   <= r_surv[w_best][TB_DEPTH-1];
            r_valid <= 1'b1;
          end
        end
        if (w_flush_req)   r_cnt  <= w_n_next;
        if (w_empty_flush) r_done <= 1'b1;
      end else begin
        // Survivors and metrics are frozen here, so w_best stays constant.
        r_bit   <= w_flush_vec[0];
        r_valid <= 1'b1;
        r_cnt   <= r_cnt - 7'd1;
        if (r_cnt == 7'd1) begin
          r_done <= 1'b1;
          r_n    <= '0;
          for (int s = 0; s < c_NSTATES; s++) begin
            r_pm[s]   <= (s == 0) ? '0 : PM_W'(64);
            r_surv[s] <= '0;
          end
        end
      end
    end
  end

  assign bus.bit_out   = r_bit;
  assign bus.valid_out = r_valid;
  assign bus.done      = r_done;
  assign bus.busy      = (r_state == ST_FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_viterbi_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_viterbi_decoder                                        |
// | Brief    : Directed self-checking bench for viterbi_decoder.         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_viterbi_decoder;

  logic Clk = 1'b0;
  logic reset = 1'b1;
  always #5 Clk = ~Clk;

  viterbi_decoder_if bus();

  viterbi_decoder #(.TB_DEPTH(42), .PM_W(8)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  bit   out_q[$];
  bit   src_q[$];
  bit   exp_q[$];
  int   done_cnt = 0;
  int   done_bad = 0;
  int   steps = 0;
  int   first_valid = -1;
  logic [5:0] enc_st = '0;
  logic       r_flush_busy = 1'b0;

  always @(negedge Clk) begin
    if (!reset) begin
      if (bus.valid_out) out_q.push_back(bus.bit_out);
      if (bus.done) begin
        done_cnt++;
        if (!bus.valid_out) done_bad++;
      end
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic enc(input logic u, output logic [1:0] ab);
    logic [6:0] d;
    d      = {u, enc_st};
    ab     = {^(d & 7'b1011011), ^(d & 7'b1111001)};
    enc_st = d[6:1];
  endtask

  task automatic clear();
    out_q.delete(); src_q.delete(); exp_q.delete();
    done_cnt = 0; done_bad = 0; steps = 0; first_valid = -1; enc_st = '0;
  endtask

  task automatic do_step(input logic [1:0] ab, input logic [1:0] vin);
    @(negedge Clk);
    bus.AB = ab; bus.valid_in = vin; bus.flush = 1'b0;
    @(posedge Clk); #1;
    if (vin != 2'b00) steps++;
    if (bus.valid_out && first_valid < 0) first_valid = steps - 1;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge Clk);
      bus.valid_in = 2'b00; bus.flush = 1'b0;
    end
  endtask

  task automatic do_flush(input logic [1:0] ab, input logic [1:0] vin);
    @(negedge Clk);
    bus.AB = ab; bus.valid_in = vin; bus.flush = 1'b1;
    @(posedge Clk); #1;
    if (vin != 2'b00) steps++;
    r_flush_busy = bus.busy;
    @(negedge Clk);
    bus.flush = 1'b0; bus.valid_in = 2'b00;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (done_cnt == 0 && k < limit) begin
      @(negedge Clk);
      k++;
    end
    idle(2);
    check(tag, done_cnt, 1);
  endtask

  task automatic cmp_stream(input string tag);
    int nerr = 0;
    check({tag, "_len"}, out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      if (out_q[i] !== exp_q[i]) nerr++;
    check({tag, "_bits"}, nerr, 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    reset = 1'b1; bus.valid_in = 2'b00; bus.flush = 1'b0;
    @(posedge Clk); #1;
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge Clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] ab;
    logic [1:0] vin;
    logic [1:0] imp [7];
    logic [1:0] pat [3];
    int sz;
    imp = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
    pat = '{2'b11, 2'b10, 2'b01};
    bus.AB = 2'b00; bus.valid_in = 2'b00; bus.flush = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_valid_out", bus.valid_out, 0);
    check("reset_bit_out", bus.bit_out, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    @(negedge Clk);
    reset = 1'b0;

    // Flush with nothing received: done alone, no bits.
    clear();
    do_flush(2'b00, 2'b00);
    idle(3);
    check("empty_done", done_cnt, 1);
    check("empty_bits", out_q.size(), 0);
    check("empty_busy", bus.busy, 0);

    // All zeros: 58 bits while running, 42 more on flush.
    clear();
    repeat (100) do_step(2'b00, 2'b11);
    idle(2);
    check("zero_run_bits", out_q.size(), 58);
    do_flush(2'b00, 2'b00);
    check("zero_busy_on_flush", r_flush_busy, 1);
    wait_done("zero_done", 200);
    check("zero_done_with_bit", done_bad, 0);
    check("zero_busy_after", bus.busy, 0);
    repeat (100) exp_q.push_back(1'b0);
    cmp_stream("zero");

    // Impulse response.
    clear();
    for (int i = 0; i < 100; i++) do_step((i < 7) ? imp[i] : 2'b00, 2'b11);
    idle(2);
    check("imp_first_valid_step", first_valid, 42);
    do_flush(2'b00, 2'b00);
    wait_done("imp_done", 200);
    exp_q.push_back(1'b1);
    repeat (99) exp_q.push_back(1'b0);
    cmp_stream("imp");

    // Random stream with one flipped coded bit per 20, alternating A/B.
    clear();
    for (int i = 0; i < 400; i++) begin
      src_q.push_back(1'($urandom_range(0, 1)));
      enc(src_q[i], ab);
      for (int j = 0; j < 2; j++) begin
        int c = 2 * i + j;
        if (c < 760 && (c % 20) == (((c / 20) % 2) ? 13 : 6)) ab[1-j] = ~ab[1-j];
      end
      do_step(ab, 2'b11);
    end
    do_flush(2'b00, 2'b00);
    wait_done("ecc_done", 200);
    exp_q = src_q;
    cmp_stream("ecc");

    // Rate 3/4 puncturing, junk on erased bits, random idle cycles.
    clear();
    for (int i = 0; i < 300; i++) begin
      src_q.push_back(1'($urandom_range(0, 1)));
      enc(src_q[i], ab);
      vin = pat[i % 3];
      ab  = (ab & vin) | (2'($urandom_range(0, 3)) & ~vin);
      if ($urandom_range(0, 3) == 0) do_step(2'($urandom_range(0, 3)), 2'b00);
      do_step(ab, vin);
    end
    check("punct_steps", steps, 300);
    do_flush(2'b00, 2'b00);
    wait_done("punct_done", 200);
    exp_q = src_q;
    cmp_stream("punct");

    // Reset mid-run, then a clean all-zero block.
    clear();
    for (int i = 0; i < 60; i++) begin
      enc(1'($urandom_range(0, 1)), ab);
      do_step(ab, 2'b11);
    end
    do_reset();
    clear();
    repeat (50) do_step(2'b00, 2'b11);
    do_flush(2'b00, 2'b00);
    wait_done("rst_zero_done", 200);
    repeat (50) exp_q.push_back(1'b0);
    cmp_stream("rst_zero");

    // Reset mid-flush stops the output.
    clear();
    for (int i = 0; i < 50; i++) begin
      enc(1'($urandom_range(0, 1)), ab);
      do_step(ab, 2'b11);
    end
    do_flush(2'b00, 2'b00);
    idle(3);
    do_reset();
    sz = out_q.size();
    idle(50);
    check("rstfl_no_more_bits", out_q.size(), sz);
    check("rstfl_no_done", done_cnt, 0);

    // Early flush on the 10th step, second flush while busy.
    clear();
    for (int i = 0; i < 10; i++) begin
      src_q.push_back(1'($urandom_range(0, 1)));
      enc(src_q[i], ab);
      if (i < 9) do_step(ab, 2'b11);
      else       do_flush(ab, 2'b11);
    end
    check("early_busy", bus.busy, 1);
    bus.flush = 1'b1;
    @(negedge Clk);
    bus.flush = 1'b0;
    wait_done("early_done", 50);
    idle(20);
    check("early_single_done", done_cnt, 1);
    exp_q = src_q;
    cmp_stream("early");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
